// File: rtl/fmadd_mantissa_adder_arbiter_pkg.sv
// Shared definitions for the mantissa-adder arbiter: FSM encoding, requester ids
// and the datapath width rule.
package fmadd_mantissa_adder_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ID_FMADD = 1'b0;
    localparam logic ID_FADD  = 1'b1;

    // Mantissa datapath holds a full product plus guard/carry room.
    function automatic int mant_width(input int man_msb);
        return 2 * man_msb + 4;
    endfunction

endpackage

// File: rtl/fmadd_mantissa_adder_arbiter_if.sv
// Request/result handshake bundle between the two adder clients, the arbiter
// and the result consumer.
interface fmadd_mantissa_adder_arbiter_if #(
    parameter int W = 48
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_mant_a;
    logic [W-1:0] req0_mant_b;
    logic         req0_eff_sub;
    logic         req0_exp_diff_chk;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_mant_a;
    logic [W-1:0] req1_mant_b;
    logic         req1_eff_sub;
    logic         req1_exp_diff_chk;

    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic [W-1:0] res_mant;
    logic         res_carry;

    modport master (
        output req0_valid, req0_mant_a, req0_mant_b, req0_eff_sub, req0_exp_diff_chk,
        output req1_valid, req1_mant_a, req1_mant_b, req1_eff_sub, req1_exp_diff_chk,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_id, res_mant, res_carry
    );

    modport slave (
        input  req0_valid, req0_mant_a, req0_mant_b, req0_eff_sub, req0_exp_diff_chk,
        input  req1_valid, req1_mant_a, req1_mant_b, req1_eff_sub, req1_exp_diff_chk,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_id, res_mant, res_carry
    );

endinterface

// File: rtl/fmadd_mantissa_adder_arbiter_adder.sv
// Combinational mantissa adder/subtractor: returns the magnitude of A +/- B with
// the raw carry, folding a negative difference back to positive.
module FMADD_Mantissa_Addition #(
    parameter int std = 31,
    parameter int man = 22,
    parameter int exp = 7
) (
    input  logic [2*man+3:0] mant_a,
    input  logic [2*man+3:0] mant_b,
    input  logic             eff_sub,
    input  logic             exp_diff_chk,
    output logic [2*man+3:0] mant,
    output logic             carry
);

    localparam int W = 2 * man + 4;

    logic [W-1:0] inc;
    logic [W-1:0] b_adj;
    logic [W-1:0] sum;

    // The field layout must describe a real FP word: sign + exponent + mantissa.
    if (std != exp + man + 2) begin : g_format_check
        $error("FMADD_Mantissa_Addition: std/exp/man do not form a valid FP format");
    end

    // exp_diff_chk set means the aligned operand already carries its own +1.
    always_comb begin
        inc          = '0;
        inc[0]       = ~exp_diff_chk;
        b_adj        = eff_sub ? (~mant_b + inc) : mant_b;
        {carry, sum} = {1'b0, mant_a} + {1'b0, b_adj};
        mant         = (eff_sub && !carry) ? (~sum + inc) : sum;
    end

endmodule

// File: rtl/fmadd_mantissa_adder_arbiter.sv
// Round-robin arbiter sharing one mantissa adder between the FMADD accumulate
// path (id 0) and the FADD/FSUB path (id 1), with registered operands and result.
module fmadd_mantissa_adder_arbiter
    import fmadd_mantissa_adder_arbiter_pkg::*;
#(
    parameter int std = 31,
    parameter int man = 22,
    parameter int exp = 7
) (
    input  logic clk,
    input  logic rst_l,
    fmadd_mantissa_adder_arbiter_if.slave bus,
    output logic busy
);

    localparam int W = mant_width(man);

    state_t       state;
    state_t       next_state;
    logic         rr_ptr;
    logic         grant_any;
    logic         grant_id;

    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_eff_sub;
    logic         op_chk;
    logic         op_id;

    logic [W-1:0] sum_mant;
    logic         sum_carry;

    logic [W-1:0] res_mant_q;
    logic         res_carry_q;
    logic         res_id_q;

    logic         req0_ready_c;
    logic         req1_ready_c;
    logic         res_valid_c;

    // rr_ptr only matters on a tie; a lone requester always wins.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = rr_ptr;
        end else begin
            grant_id = bus.req1_valid ? ID_FADD : ID_FMADD;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_any) next_state = EXEC;
            EXEC:    next_state = DONE;
            DONE:    if (bus.res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Readies are withheld while reset is held so nothing is accepted into cleared flops.
    always_comb begin
        req0_ready_c = rst_l && (state == IDLE) && grant_any && (grant_id == ID_FMADD);
        req1_ready_c = rst_l && (state == IDLE) && grant_any && (grant_id == ID_FADD);
        res_valid_c  = (state == DONE);
        busy         = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rr_ptr      <= ID_FMADD;
            op_a        <= '0;
            op_b        <= '0;
            op_eff_sub  <= 1'b0;
            op_chk      <= 1'b0;
            op_id       <= 1'b0;
            res_mant_q  <= '0;
            res_carry_q <= 1'b0;
            res_id_q    <= 1'b0;
        end else begin
            if (state == IDLE && grant_any) begin
                rr_ptr <= ~grant_id;
                op_id  <= grant_id;
                if (grant_id == ID_FADD) begin
                    op_a       <= bus.req1_mant_a;
                    op_b       <= bus.req1_mant_b;
                    op_eff_sub <= bus.req1_eff_sub;
                    op_chk     <= bus.req1_exp_diff_chk;
                end else begin
                    op_a       <= bus.req0_mant_a;
                    op_b       <= bus.req0_mant_b;
                    op_eff_sub <= bus.req0_eff_sub;
                    op_chk     <= bus.req0_exp_diff_chk;
                end
            end
            if (state == EXEC) begin
                res_mant_q  <= sum_mant;
                res_carry_q <= sum_carry;
                res_id_q    <= op_id;
            end
        end
    end

    FMADD_Mantissa_Addition #(
        .std (std),
        .man (man),
        .exp (exp)
    ) u_mant_add (
        .mant_a       (op_a),
        .mant_b       (op_b),
        .eff_sub      (op_eff_sub),
        .exp_diff_chk (op_chk),
        .mant         (sum_mant),
        .carry        (sum_carry)
    );

    assign bus.req0_ready = req0_ready_c;
    assign bus.req1_ready = req1_ready_c;
    assign bus.res_valid  = res_valid_c;
    assign bus.res_id     = res_id_q;
    assign bus.res_mant   = res_mant_q;
    assign bus.res_carry  = res_carry_q;

endmodule

// File: tb/tb_fmadd_mantissa_adder_arbiter.sv
// Scoreboard bench for the shared mantissa-adder arbiter: a stimulus process queues
// expected results from an arithmetic reference model, a monitor retires them.
module tb_fmadd_mantissa_adder_arbiter;
    import fmadd_mantissa_adder_arbiter_pkg::*;

    localparam int W = mant_width(22);
    localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         chk;
    } op_t;

    typedef struct packed {
        logic         id;
        logic [W-1:0] mant;
        logic         carry;
    } result_t;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic busy;
    int   n_vectors = 0;
    int   n_miscompares = 0;
    int   ready_mode = 1;
    logic rr_model = 1'b0;
    result_t exp_q[$];

    fmadd_mantissa_adder_arbiter_if #(.W(W)) bus ();

    fmadd_mantissa_adder_arbiter #(
        .std (31),
        .man (22),
        .exp (7)
    ) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Consumer readiness: 0 = random, 1 = always ready, 2 = held off.
    always @(negedge clk) begin
        if (ready_mode == 0) bus.res_ready = ($urandom_range(0, 3) != 0);
        else                 bus.res_ready = (ready_mode == 1);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference arithmetic: subtraction as (2^W-1 - x) + 1 on 64-bit integers.
    function automatic result_t refModel(input logic id, input op_t op);
        logic [63:0] inc, bp, s;
        result_t r;
        inc     = op.chk ? 64'd0 : 64'd1;
        bp      = op.sub ? (((MASK - {16'd0, op.b}) + inc) & MASK) : {16'd0, op.b};
        s       = {16'd0, op.a} + bp;
        r.carry = s[W];
        s       = s & MASK;
        if (op.sub && !r.carry) s = ((MASK - s) + inc) & MASK;
        r.mant  = s[W-1:0];
        r.id    = id;
        return r;
    endfunction

    function automatic op_t mkOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic chk);
        op_t o;
        o.a = a; o.b = b; o.sub = sub; o.chk = chk;
        return o;
    endfunction

    function automatic op_t randOp();
        op_t o;
        o.a   = W'({$urandom, $urandom});
        o.b   = ($urandom_range(0, 7) == 0) ? o.a : W'({$urandom, $urandom});
        o.sub = 1'($urandom);
        o.chk = 1'($urandom);
        return o;
    endfunction

    task automatic dropValids();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Present requests until one is granted; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic v0, input op_t o0, input logic v1, input op_t o1);
        logic exp_id;
        bit   done;
        done = 0;
        @(negedge clk);
        bus.req0_valid = v0; bus.req0_mant_a = o0.a; bus.req0_mant_b = o0.b;
        bus.req0_eff_sub = o0.sub; bus.req0_exp_diff_chk = o0.chk;
        bus.req1_valid = v1; bus.req1_mant_a = o1.a; bus.req1_mant_b = o1.b;
        bus.req1_eff_sub = o1.sub; bus.req1_exp_diff_chk = o1.chk;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                exp_id = (v0 && v1) ? rr_model : (v1 ? ID_FADD : ID_FMADD);
                checkOutput("grant_req0_ready", bus.req0_ready, exp_id == ID_FMADD);
                checkOutput("grant_req1_ready", bus.req1_ready, exp_id == ID_FADD);
                exp_q.push_back(refModel(exp_id, (exp_id == ID_FADD) ? o1 : o0));
                rr_model = ~exp_id;
                @(posedge clk);
                #1;
                dropValids();
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL grant_timeout: got no ready, expected a grant within 40 cycles");
            dropValids();
        end
    endtask

    initial begin
        result_t r;
        forever begin
            @(negedge clk);
            #2;
            if (rst_l && bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    n_vectors++;
                    n_miscompares++;
                    $display("[TB] FAIL unexpected_result: got id %0d mant 0x%0h, expected no result", bus.res_id, bus.res_mant);
                end else begin
                    r = exp_q.pop_front();
                    checkOutput("res_id", bus.res_id, r.id);
                    checkOutput("res_mant", bus.res_mant, r.mant);
                    checkOutput("res_carry", bus.res_carry, r.carry);
                end
            end
        end
    end

    initial begin
        op_t none;
        op_t o0, o1;
        logic [W+1:0] snap;
        int sel;
        int cyc;

        none = mkOp('0, '0, 1'b0, 1'b0);
        dropValids();
        bus.req0_mant_a = '0; bus.req0_mant_b = '0; bus.req0_eff_sub = 0; bus.req0_exp_diff_chk = 0;
        bus.req1_mant_a = '0; bus.req1_mant_b = '0; bus.req1_eff_sub = 0; bus.req1_exp_diff_chk = 0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_res_valid", bus.res_valid, 0);
        checkOutput("rst_res_id", bus.res_id, 0);
        checkOutput("rst_res_mant", bus.res_mant, 0);
        checkOutput("rst_res_carry", bus.res_carry, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_readies", {bus.req0_ready, bus.req1_ready}, 0);
        @(negedge clk);
        rst_l = 1'b1;

        $display("[TB] directed add / subtract / overflow");
        applyStimulus(1, mkOp(W'(3), W'(5), 0, 1), 0, none);
        checkOutput("latency_exec_valid", bus.res_valid, 0);
        checkOutput("latency_exec_busy", busy, 1);
        @(posedge clk);
        #1;
        checkOutput("latency_done_valid", bus.res_valid, 1);
        applyStimulus(0, none, 1, mkOp(W'(5), W'(3), 1, 0));
        applyStimulus(1, mkOp(W'(3), W'(5), 1, 0), 0, none);
        applyStimulus(0, none, 1, mkOp(W'(48'h800000000000), W'(48'h800000000000), 0, 1));

        $display("[TB] both requesters contending");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, randOp(), 1, randOp());
        end

        $display("[TB] randomized traffic");
        ready_mode = 0;
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(1, 3);
            o0 = randOp();
            o1 = randOp();
            applyStimulus(sel[0], o0, sel[1], o1);
        end
        ready_mode = 1;
        for (cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) @(negedge clk);

        $display("[TB] backpressure");
        ready_mode = 2;
        repeat (2) @(negedge clk);
        applyStimulus(0, none, 1, mkOp(W'(7), W'(1), 0, 1));
        for (cyc = 0; cyc < 10 && !bus.res_valid; cyc++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("bp_res_valid", bus.res_valid, 1);
        snap = {bus.res_id, bus.res_mant, bus.res_carry};
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_hold_result", {bus.res_id, bus.res_mant, bus.res_carry}, snap);
            checkOutput("bp_hold_valid", bus.res_valid, 1);
            checkOutput("bp_busy", busy, 1);
            checkOutput("bp_no_ready", {bus.req0_ready, bus.req1_ready}, 0);
        end
        dropValids();
        ready_mode = 1;
        for (cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) @(negedge clk);

        $display("[TB] reset during execution");
        applyStimulus(1, mkOp(W'(9), W'(4), 0, 1), 0, none);
        rst_l = 1'b0;
        #1;
        checkOutput("midrst_res_valid", bus.res_valid, 0);
        checkOutput("midrst_res_id", bus.res_id, 0);
        checkOutput("midrst_res_mant", bus.res_mant, 0);
        checkOutput("midrst_res_carry", bus.res_carry, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_readies", {bus.req0_ready, bus.req1_ready}, 0);
        exp_q.delete();
        rr_model = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checkOutput("postrst_no_result", bus.res_valid, 0);
        end
        applyStimulus(1, randOp(), 1, randOp());

        for (cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL drain: got %0d outstanding results, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
